ysyx_22040386_pipe_stage: RTL and testbench

YSYX_22040386_PIPE_STAGE -- requirements
Module: ysyx_22040386_PIPE_STAGE

---
 rtl/ysyx_22040386_pipe_pkg.sv | 26 ++
 rtl/ysyx_22040386_pipe_slot.sv | 43 ++++
 rtl/ysyx_22040386_pipe_stage.sv | 127 ++++++++++++
 tb/tb_ysyx_22040386_pipe_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040386_pipe_pkg.sv
// Shared definitions for ysyx_22040386 pipeline stages: NOP control value,
// control-field bit positions and the main-slot load source selector.
package ysyx_22040386_pipe_pkg;

    localparam int unsigned PIPE_CTRL_W = 16;
    localparam logic [PIPE_CTRL_W-1:0] PIPE_CTRL_NOP = '0;

    // Control-field bit positions shared by every stage instance
    localparam int unsigned CTRL_BIT_REG_WEN  = 0;
    localparam int unsigned CTRL_BIT_MEM_RD   = 1;
    localparam int unsigned CTRL_BIT_MEM_WR   = 2;
    localparam int unsigned CTRL_BIT_BRANCH   = 3;
    localparam int unsigned CTRL_BIT_JUMP     = 4;
    localparam int unsigned CTRL_BIT_CSR      = 5;
    localparam int unsigned CTRL_BIT_TRAP     = 6;
    localparam int unsigned CTRL_ALU_OP_LSB   = 8;
    localparam int unsigned CTRL_ALU_OP_MSB   = 11;
    localparam int unsigned CTRL_MEM_SIZE_LSB = 12;
    localparam int unsigned CTRL_MEM_SIZE_MSB = 13;

    typedef enum logic {
        SRC_IN   = 1'b0,
        SRC_SKID = 1'b1
    } pipe_src_e;

endpackage

// File: rtl/ysyx_22040386_pipe_slot.sv
// One pipeline entry: valid + control + payload registers with load, drop and kill.
// The control register is forced to CTRL_NOP whenever the entry becomes invalid.
module ysyx_22040386_pipe_slot #(
    parameter int unsigned       CTRL_W   = 16,
    parameter int unsigned       DATA_W   = 256,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
    input  logic              i_PIPE_SLOT_clk,
    input  logic              i_PIPE_SLOT_rst_n,
    input  logic              i_PIPE_SLOT_kill,
    input  logic              i_PIPE_SLOT_load,
    input  logic              i_PIPE_SLOT_drop,
    input  logic [CTRL_W-1:0] i_PIPE_SLOT_ctrl,
    input  logic [DATA_W-1:0] i_PIPE_SLOT_data,
    output logic              o_PIPE_SLOT_valid,
    output logic [CTRL_W-1:0] o_PIPE_SLOT_ctrl,
    output logic [DATA_W-1:0] o_PIPE_SLOT_data
);

    // Kill outranks load so a flushed incoming entry never lands
    always_ff @(posedge i_PIPE_SLOT_clk or negedge i_PIPE_SLOT_rst_n) begin
        if (!i_PIPE_SLOT_rst_n) begin
            o_PIPE_SLOT_valid <= 1'b0;
            o_PIPE_SLOT_ctrl  <= CTRL_NOP;
        end else if (i_PIPE_SLOT_kill || (i_PIPE_SLOT_drop && !i_PIPE_SLOT_load)) begin
            o_PIPE_SLOT_valid <= 1'b0;
            o_PIPE_SLOT_ctrl  <= CTRL_NOP;
        end else if (i_PIPE_SLOT_load) begin
            o_PIPE_SLOT_valid <= 1'b1;
            o_PIPE_SLOT_ctrl  <= i_PIPE_SLOT_ctrl;
        end
    end

    // Payload only moves with a real load; flush and bubble leave it intact
    always_ff @(posedge i_PIPE_SLOT_clk or negedge i_PIPE_SLOT_rst_n) begin
        if (!i_PIPE_SLOT_rst_n) begin
            o_PIPE_SLOT_data <= '0;
        end else if (i_PIPE_SLOT_load && !i_PIPE_SLOT_kill) begin
            o_PIPE_SLOT_data <= i_PIPE_SLOT_data;
        end
    end

endmodule

// File: rtl/ysyx_22040386_pipe_stage.sv
// Valid/ready pipeline stage with optional skid entry, bubble hold and flush.
// SKID=1: two entries, in_ready registered; SKID=0: single entry.
module ysyx_22040386_pipe_stage
    import ysyx_22040386_pipe_pkg::*;
#(
    parameter int unsigned       CTRL_W   = PIPE_CTRL_W,
    parameter int unsigned       DATA_W   = 256,
    parameter logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(PIPE_CTRL_NOP),
    parameter int unsigned       SKID     = 1
) (
    input  logic              i_PIPE_STAGE_clk,
    input  logic              i_PIPE_STAGE_rst_n,
    input  logic              i_PIPE_STAGE_flush,
    input  logic              i_PIPE_STAGE_bubble,
    input  logic              i_PIPE_STAGE_in_valid,
    output logic              o_PIPE_STAGE_in_ready,
    input  logic [CTRL_W-1:0] i_PIPE_STAGE_in_ctrl,
    input  logic [DATA_W-1:0] i_PIPE_STAGE_in_data,
    output logic              o_PIPE_STAGE_out_valid,
    input  logic              i_PIPE_STAGE_out_ready,
    output logic [CTRL_W-1:0] o_PIPE_STAGE_out_ctrl,
    output logic [DATA_W-1:0] o_PIPE_STAGE_out_data,
    output logic [1:0]        o_PIPE_STAGE_count
);

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    logic              in_fire;
    logic              out_fire;
    logic              main_load;
    logic              main_drop;
    logic              skid_load;
    logic              skid_drop;
    pipe_src_e         main_src;
    logic [CTRL_W-1:0] main_in_ctrl;
    logic [DATA_W-1:0] main_in_data;

    assign in_fire  = i_PIPE_STAGE_in_valid & o_PIPE_STAGE_in_ready & ~i_PIPE_STAGE_bubble;
    assign out_fire = main_valid & i_PIPE_STAGE_out_ready;

    // Skid always refills main first so main stays the FIFO head
    always_comb begin
        main_load = 1'b0;
        main_drop = 1'b0;
        skid_load = 1'b0;
        skid_drop = 1'b0;
        main_src  = SRC_IN;
        if (out_fire && skid_valid) begin
            main_load = 1'b1;
            main_src  = SRC_SKID;
            if (in_fire) begin
                skid_load = 1'b1;
            end else begin
                skid_drop = 1'b1;
            end
        end else if (in_fire) begin
            if (!main_valid || out_fire) begin
                main_load = 1'b1;
            end else begin
                skid_load = 1'b1;
            end
        end else if (out_fire) begin
            main_drop = 1'b1;
        end
    end

    assign main_in_ctrl = (main_src == SRC_SKID) ? skid_ctrl : i_PIPE_STAGE_in_ctrl;
    assign main_in_data = (main_src == SRC_SKID) ? skid_data : i_PIPE_STAGE_in_data;

    ysyx_22040386_pipe_slot #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CTRL_NOP (CTRL_NOP)
    ) u_main (
        .i_PIPE_SLOT_clk   (i_PIPE_STAGE_clk),
        .i_PIPE_SLOT_rst_n (i_PIPE_STAGE_rst_n),
        .i_PIPE_SLOT_kill  (i_PIPE_STAGE_flush),
        .i_PIPE_SLOT_load  (main_load),
        .i_PIPE_SLOT_drop  (main_drop),
        .i_PIPE_SLOT_ctrl  (main_in_ctrl),
        .i_PIPE_SLOT_data  (main_in_data),
        .o_PIPE_SLOT_valid (main_valid),
        .o_PIPE_SLOT_ctrl  (main_ctrl),
        .o_PIPE_SLOT_data  (main_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            ysyx_22040386_pipe_slot #(
                .CTRL_W   (CTRL_W),
                .DATA_W   (DATA_W),
                .CTRL_NOP (CTRL_NOP)
            ) u_skid (
                .i_PIPE_SLOT_clk   (i_PIPE_STAGE_clk),
                .i_PIPE_SLOT_rst_n (i_PIPE_STAGE_rst_n),
                .i_PIPE_SLOT_kill  (i_PIPE_STAGE_flush),
                .i_PIPE_SLOT_load  (skid_load),
                .i_PIPE_SLOT_drop  (skid_drop),
                .i_PIPE_SLOT_ctrl  (i_PIPE_STAGE_in_ctrl),
                .i_PIPE_SLOT_data  (i_PIPE_STAGE_in_data),
                .o_PIPE_SLOT_valid (skid_valid),
                .o_PIPE_SLOT_ctrl  (skid_ctrl),
                .o_PIPE_SLOT_data  (skid_data)
            );
            // Straight from a flop: no path from out_ready
            assign o_PIPE_STAGE_in_ready = ~skid_valid;
        end else begin : g_noskid
            logic unused_skid_ctl;
            assign skid_valid            = 1'b0;
            assign skid_ctrl             = CTRL_NOP;
            assign skid_data             = '0;
            assign unused_skid_ctl       = skid_load ^ skid_drop;
            assign o_PIPE_STAGE_in_ready = ~main_valid | i_PIPE_STAGE_out_ready;
        end
    endgenerate

    assign o_PIPE_STAGE_out_valid = main_valid;
    assign o_PIPE_STAGE_out_ctrl  = main_ctrl;
    assign o_PIPE_STAGE_out_data  = main_data;
    assign o_PIPE_STAGE_count     = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_ysyx_22040386_pipe_stage.sv
// Bench for ysyx_22040386_pipe_stage: SKID=1 and SKID=0 instances share stimulus
// and are each checked against a queue-based reference model.
module tb_ysyx_22040386_pipe_stage;

    localparam int unsigned CW = 16;
    localparam int unsigned DW = 256;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          flush = 1'b0;
    logic          bubble = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;

    logic          in_ready  [2];
    logic          out_valid [2];
    logic [CW-1:0] out_ctrl  [2];
    logic [DW-1:0] out_data  [2];
    logic [1:0]    count     [2];

    ent_t          q [2][$];
    logic [DW-1:0] last_head [2];
    int            n_checks = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    ysyx_22040386_pipe_stage #(.SKID(1)) dut1 (
        .i_PIPE_STAGE_clk       (clk),
        .i_PIPE_STAGE_rst_n     (rst_n),
        .i_PIPE_STAGE_flush     (flush),
        .i_PIPE_STAGE_bubble    (bubble),
        .i_PIPE_STAGE_in_valid  (in_valid),
        .o_PIPE_STAGE_in_ready  (in_ready[1]),
        .i_PIPE_STAGE_in_ctrl   (in_ctrl),
        .i_PIPE_STAGE_in_data   (in_data),
        .o_PIPE_STAGE_out_valid (out_valid[1]),
        .i_PIPE_STAGE_out_ready (out_ready),
        .o_PIPE_STAGE_out_ctrl  (out_ctrl[1]),
        .o_PIPE_STAGE_out_data  (out_data[1]),
        .o_PIPE_STAGE_count     (count[1])
    );

    ysyx_22040386_pipe_stage #(.SKID(0)) dut0 (
        .i_PIPE_STAGE_clk       (clk),
        .i_PIPE_STAGE_rst_n     (rst_n),
        .i_PIPE_STAGE_flush     (flush),
        .i_PIPE_STAGE_bubble    (bubble),
        .i_PIPE_STAGE_in_valid  (in_valid),
        .o_PIPE_STAGE_in_ready  (in_ready[0]),
        .i_PIPE_STAGE_in_ctrl   (in_ctrl),
        .i_PIPE_STAGE_in_data   (in_data),
        .o_PIPE_STAGE_out_valid (out_valid[0]),
        .i_PIPE_STAGE_out_ready (out_ready),
        .o_PIPE_STAGE_out_ctrl  (out_ctrl[0]),
        .o_PIPE_STAGE_out_data  (out_data[0]),
        .o_PIPE_STAGE_count     (count[0])
    );

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Capacity rule: two entries with skid, otherwise one entry that may be replaced in-cycle
    function automatic bit exp_ready(int k, logic r);
        if (k == 1) return q[k].size() < 2;
        return (q[k].size() == 0) || r;
    endfunction

    function automatic void model_step(int k, bit rdy);
        bit inf;
        bit outf;
        inf  = in_valid && rdy && !bubble;
        outf = (q[k].size() > 0) && out_ready;
        if (outf) void'(q[k].pop_front());
        if (flush) q[k].delete();
        else if (inf) q[k].push_back('{ctrl: in_ctrl, data: in_data});
        if (q[k].size() > 0) last_head[k] = q[k][0].data;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            q[k].delete();
            last_head[k] = '0;
        end
    endfunction

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("out_valid[%0d]", k), DW'(out_valid[k]), DW'(q[k].size() > 0));
            if (q[k].size() > 0)
                check_val($sformatf("out_ctrl[%0d]", k), DW'(out_ctrl[k]), DW'(q[k][0].ctrl));
            else
                check_val($sformatf("out_ctrl_nop[%0d]", k), DW'(out_ctrl[k]), '0);
            check_val($sformatf("out_data[%0d]", k), out_data[k], last_head[k]);
            check_val($sformatf("count[%0d]", k), DW'(count[k]), DW'(q[k].size()));
        end
    endtask

    // Called just after a falling edge; returns just after the next falling edge
    task automatic cycle(input logic v, input logic b, input logic f, input logic r,
                         input logic [CW-1:0] c, input logic [DW-1:0] d);
        bit   er [2];
        logic held;
        in_valid = v; bubble = b; flush = f; out_ready = r; in_ctrl = c; in_data = d;
        #1;
        for (int k = 0; k < 2; k++) begin
            er[k] = exp_ready(k, r);
            check_val($sformatf("in_ready[%0d]", k), DW'(in_ready[k]), DW'(er[k]));
        end
        held = in_ready[1];
        out_ready = ~r;
        #1;
        check_val("skid_ready_indep", DW'(in_ready[1]), DW'(held));
        out_ready = r;
        #1;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k, er[k]);
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [DW-1:0] rand_data();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [DW-1:0] keep_data;
        model_reset();
        out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("rst_in_ready[%0d]", k), DW'(in_ready[k]), DW'(1));
            check_val($sformatf("rst_out_valid[%0d]", k), DW'(out_valid[k]), '0);
            check_val($sformatf("rst_count[%0d]", k), DW'(count[k]), '0);
            check_val($sformatf("rst_out_ctrl[%0d]", k), DW'(out_ctrl[k]), '0);
            check_val($sformatf("rst_out_data[%0d]", k), out_data[k], '0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Single entry through an empty stage
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h00A5, DW'(16'h1234));
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("lat1_valid[%0d]", k), DW'(out_valid[k]), DW'(1));
            check_val($sformatf("lat1_ctrl[%0d]", k), DW'(out_ctrl[k]), DW'(16'h00A5));
            check_val($sformatf("lat1_data[%0d]", k), out_data[k], DW'(16'h1234));
            check_val($sformatf("lat1_count[%0d]", k), DW'(count[k]), DW'(1));
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);

        // Backpressure: A, B, C offered while downstream stalls
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0A0A, DW'(32'hAAAA_0001));
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0B0B, DW'(32'hBBBB_0002));
        check_val("full_count", DW'(count[1]), DW'(2));
        check_val("full_in_ready", DW'(in_ready[1]), '0);
        check_val("full_main_ctrl", DW'(out_ctrl[1]), DW'(16'h0A0A));
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, (i > 0), 16'h0C0C, DW'(32'hCCCC_0003));
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);

        // One bubble cycle while streaming
        for (int t = 0, i = 0; t < 8; t++) begin
            cycle(1'b1, (t == 3), 1'b0, 1'b1, CW'(16'h0100 + i), DW'(32'hD000_0000 + i));
            if (t == 3) begin
                check_val("bubble_out_valid", DW'(out_valid[1]), '0);
                check_val("bubble_out_ctrl", DW'(out_ctrl[1]), '0);
            end else begin
                i++;
            end
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);

        // Full stage flushed while a new entry is offered
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0E0E, DW'(32'hEEEE_0005));
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0F0F, DW'(32'hFFFF_0006));
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 16'h0707, DW'(32'h7777_0007));
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("flush_valid[%0d]", k), DW'(out_valid[k]), '0);
            check_val($sformatf("flush_count[%0d]", k), DW'(count[k]), '0);
            check_val($sformatf("flush_data[%0d]", k), out_data[k], DW'(32'hEEEE_0005));
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);

        // Asynchronous reset between edges while streaming
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0111, DW'(32'h1111_0008));
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0222, DW'(32'h2222_0009));
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("arst_valid[%0d]", k), DW'(out_valid[k]), '0);
            check_val($sformatf("arst_ctrl[%0d]", k), DW'(out_ctrl[k]), '0);
            check_val($sformatf("arst_count[%0d]", k), DW'(count[k]), '0);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0333, DW'(32'h3333_000A));
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("post_rst_valid[%0d]", k), DW'(out_valid[k]), DW'(1));
            check_val($sformatf("post_rst_ctrl[%0d]", k), DW'(out_ctrl[k]), DW'(16'h0333));
        end

        // Random traffic
        for (int n = 0; n < 10000; n++) begin
            keep_data = rand_data();
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 31) == 0, $urandom_range(0, 2) != 0,
                  CW'($urandom()), keep_data);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
